program_loader: RTL and testbench

Byte-stream boot loader that fills the CPU's 256 x 32-bit instruction memory through its write port and holds the CPU until a complete, checksum-verified program is in place. It sits between an external byte source (UART receiver, debug bridge or testbench) and the instruction memory. It is the writer for the memory that the CPU fetch path reads. On success it releases `cpu_hold` so the CPU starts fetching from address 0.

---
 rtl/program_loader.sv | 137 +++++++++++++
 tb/tb_program_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Byte-stream boot loader. Receives a framed program
//             (A5, N, 4N data bytes MSB first, XOR checksum), writes each
//             32-bit word into the CPU instruction memory as it arrives and
//             releases cpu_hold only after the checksum matches.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             in_data/in_valid/   - incoming byte stream (valid/ready)
//             in_ready
//             mem_addr/mem_data/  - instruction memory write port
//             mem_we
//             cpu_hold            - freezes the CPU while high
//             done / error        - load verified / checksum mismatch
//             words_loaded        - words written in the current frame
//  Revision : 1.0 - initial release
// ============================================================================
module program_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic                  mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_COUNT = 3'd1,
    ST_DATA  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   target;    // words expected in this frame
  logic [ADDR_WIDTH-1:0] addr;      // next write address (wraps)
  logic [1:0]            byte_idx;  // byte position within current word
  logic [23:0]           word_reg;  // first three bytes of current word
  logic [7:0]            csum;      // running XOR of data bytes

  wire                   xfer     = in_valid && in_ready;
  wire [ADDR_WIDTH:0]    next_cnt = words_loaded + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_SYNC;
      in_ready     <= 1'b1;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      words_loaded <= '0;
      target       <= '0;
      addr         <= '0;
      byte_idx     <= '0;
      word_reg     <= '0;
      csum         <= '0;
    end else begin
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          ST_SYNC: begin
            if (in_data == SYNC_BYTE) state <= ST_COUNT;
          end

          ST_COUNT: begin
            // A count of zero encodes a full memory image.
            if (in_data == 8'd0)
              target <= {1'b1, {ADDR_WIDTH{1'b0}}};
            else
              target <= (ADDR_WIDTH+1)'(in_data);
            addr         <= '0;
            words_loaded <= '0;
            byte_idx     <= '0;
            word_reg     <= '0;
            csum         <= '0;
            state        <= ST_DATA;
          end

          ST_DATA: begin
            csum     <= csum ^ in_data;
            word_reg <= {word_reg[15:0], in_data};
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              mem_data     <= {word_reg, in_data};
              mem_addr     <= addr;
              mem_we       <= 1'b1;
              addr         <= addr + 1'b1;
              words_loaded <= next_cnt;
              if (next_cnt == target) state <= ST_CHECK;
            end
          end

          ST_CHECK: begin
            if (in_data == csum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              in_ready <= 1'b0;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end

          ST_ERROR: begin
            if (in_data == SYNC_BYTE) begin
              error <= 1'b0;
              state <= ST_COUNT;
            end
          end

          default: begin
            // ST_DONE never sees a transfer (in_ready is low); hold state.
            state <= state;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_program_loader
//  Purpose  : Self-checking bench for program_loader. Expected memory writes
//             are queued by the stimulus and popped by an independent
//             monitor whenever mem_we is seen; status outputs are compared
//             against hand-derived values after each frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_we;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [39:0] exp_q[$];     // {addr, data} of expected writes
  logic [31:0] frame_words[$];

  program_loader #(.ADDR_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_we       (mem_we),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_data);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_data} !== e) begin
          failures++;
          $display("FAIL mem_write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                   mem_addr, mem_data, e[39:32], e[31:0]);
        end
      end
    end
  end

  // Drive one byte; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (in_ready !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sends A5, N, frame_words, checksum (xor'd with bad_xor); queues writes.
  task automatic send_frame(input logic [7:0] n, input logic [7:0] bad_xor, input bit gaps);
    logic [7:0] cs;
    logic [7:0] a;
    cs = 8'h00;
    a  = 8'h00;
    send_byte(8'hA5, gaps);
    send_byte(n, gaps);
    foreach (frame_words[i]) begin
      exp_q.push_back({a, frame_words[i]});
      a = a + 8'd1;
      for (int k = 3; k >= 0; k--) begin
        cs = cs ^ frame_words[i][k*8 +: 8];
        send_byte(frame_words[i][k*8 +: 8], gaps);
      end
    end
    send_byte(cs ^ bad_xor, gaps);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_error"},    32'(error),    32'd0);
    chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_data"}, mem_data,      32'd0);
    chk({tag, "_words"},    32'(words_loaded), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // 1. Reset state
    do_reset();
    check_reset_values("rst");

    // 2. Single-word frame 0x12345678 (checksum 0x08)
    frame_words = '{32'h12345678};
    send_frame(8'd1, 8'h00, 1'b0);
    chk("f1_done",     32'(done),         32'd1);
    chk("f1_cpu_hold", 32'(cpu_hold),     32'd0);
    chk("f1_words",    32'(words_loaded), 32'd1);
    chk("f1_in_ready", 32'(in_ready),     32'd0);
    chk("f1_error",    32'(error),        32'd0);

    // 3. In DONE, hold A5 valid for 10 cycles: nothing may move
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("hold_done",  32'(done),         32'd1);
    chk("hold_words", 32'(words_loaded), 32'd1);

    // 4. Leading junk, two words, random valid gaps
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    chk("junk_words", 32'(words_loaded), 32'd0);
    frame_words = '{32'h00000001, 32'h00000002};
    send_frame(8'd2, 8'h00, 1'b1);
    chk("f2_done",  32'(done),         32'd1);
    chk("f2_words", 32'(words_loaded), 32'd2);

    // 5. Bad checksum (04 instead of 03), junk, then a correct frame
    do_reset();
    send_frame(8'd2, 8'h07, 1'b0);
    chk("bad_error",    32'(error),    32'd1);
    chk("bad_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("bad_done",     32'(done),     32'd0);
    chk("bad_in_ready", 32'(in_ready), 32'd1);
    chk("bad_words",    32'(words_loaded), 32'd2);
    send_byte(8'h33, 1'b0);
    chk("bad_junk_error", 32'(error), 32'd1);
    frame_words = '{32'hDEADBEEF, 32'hCAFEF00D};
    send_frame(8'd2, 8'h00, 1'b0);
    chk("resync_error", 32'(error),    32'd0);
    chk("resync_done",  32'(done),     32'd1);
    chk("resync_hold",  32'(cpu_hold), 32'd0);

    // 6. N=0: full 256-word image, word i = i
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(32'(i));
    send_frame(8'd0, 8'h00, 1'b0);
    chk("full_words", 32'(words_loaded), 32'd256);
    chk("full_done",  32'(done),         32'd1);
    chk("full_last_addr", 32'(mem_addr), 32'd255);

    // 7. Reset mid-frame (after 2nd byte of word 1 of an N=3 frame)
    do_reset();
    send_byte(8'hA5, 1'b0);
    send_byte(8'd3, 1'b0);
    exp_q.push_back({8'h00, 32'h11223344});
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    // Reset with a byte offered at the same edge: reset must win.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk); #1;
    check_reset_values("midrst");
    in_valid = 1'b0;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    frame_words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
    send_frame(8'd3, 8'h00, 1'b0);
    chk("reload_done",  32'(done),         32'd1);
    chk("reload_words", 32'(words_loaded), 32'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
